fp_mult_arbiter: RTL and testbench
==================================

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one IEEE-754 single-precision multiplier (legal range 2..8).
REQ-002 Parameter LAT, default 4, fixed pipeline latency of the shared multiplier in cycles (legal range 1..16).
REQ-003 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; sampled on a rising clk edge.
REQ-005 Port req_valid  input  NREQ  per-requester request strobe; bit i high means requester i presents operands.
REQ-006 Port req_x  input  32*NREQ  packed operand x; slice [32i+31:32i] belongs to requester i.
REQ-007 Port req_y  input  32*NREQ  packed operand y; same slicing as req_x.
REQ-008 Port req_ready  output  NREQ  one-hot grant; bit i high means requester i's operands are accepted this cycle.
REQ-009 Port m_x  output  32  operand x driven to the shared multiplier.
REQ-010 Port m_y  output  32  operand y driven to the shared multiplier.
REQ-011 Port m_valid  output  1  issue strobe to the shared multiplier.
REQ-012 Port m_out  input  32  multiplier result, valid exactly LAT cycles after the matching m_valid.
REQ-013 Port rsp_valid  output  NREQ  one-hot result strobe for the owning requester; one cycle wide.
REQ-014 Port rsp_data  output  32  result word qualified by rsp_valid.
REQ-015 Port inflight  output  5  count of issued operations not yet returned.

Function
REQ-016 Handshake: a transfer occurs on any cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 A requester holds req_valid, req_x and req_y stable until it is granted.
REQ-018 req_ready is combinational from req_valid and the priority pointer, with at most one bit high.
REQ-019 Arbitration is round-robin: search starts at index ptr and wraps modulo NREQ; the first asserted req_valid wins.
REQ-020 On a grant to requester g, ptr loads (g+1) mod NREQ at the next edge; with no grant, ptr holds.
REQ-021 The arbiter issues at most one operation per cycle and sustains full throughput, with no bubbles when requests are continuous.
REQ-022 On a grant, m_x/m_y equal the granted requester's operands in the same cycle and m_valid is high; with no grant, m_valid is 0 and m_x/m_y are 0.
REQ-023 A LAT-deep tag pipeline carries {valid, requester id} for each issue and advances every cycle.
REQ-024 When the tag pipeline output is valid, rsp_valid[id] = 1 and rsp_data = m_out in that cycle; otherwise rsp_valid = 0 and rsp_data = 0.
REQ-025 Results return strictly in issue order; total latency from handshake to rsp_valid is exactly LAT cycles.
REQ-026 inflight increments on issue and decrements on return; a simultaneous issue and return leaves it unchanged; it never exceeds LAT.
REQ-027 Result data passes through unmodified: no rounding, NaN or sign handling occurs in this block.

Reset
REQ-028 While reset = 0 at a rising edge: ptr = 0, all tag-pipeline valid bits = 0, inflight = 0.
REQ-029 During reset, req_ready, m_valid, m_x, m_y, rsp_valid and rsp_data are all 0, regardless of req_valid.
REQ-030 Reset asserted mid-operation discards every in-flight tag; no rsp_valid fires for operations issued before reset, even though m_out still returns them.
REQ-031 The first grant after reset release can occur in the first cycle with reset = 1.

Verification
REQ-032 Single request: NREQ=4, LAT=4, requester 1 presents x=0x40000000 and y=0x40400000 for one cycle -> req_ready = 0010 that cycle; 4 cycles later rsp_valid = 0010 and rsp_data = 0x40C00000; inflight goes 0 → 1 → 0.
REQ-033 Contention: all four requesters valid continuously from reset release -> grant order 0,1,2,3,0,…; one m_valid per cycle; responses arrive in the same order, LAT cycles later.
REQ-034 Pointer wrap: ptr = 3 and requesters 0 and 2 valid -> requester 0 is granted and ptr becomes 1.
REQ-035 Simultaneous issue and return: with a back-to-back stream, inflight holds at 4 (LAT) and never reaches 5.
REQ-036 Mid-flight reset: issue 3 operations, then drive reset = 0 for 1 cycle -> zero rsp_valid pulses over the following LAT cycles and inflight = 0.
REQ-037 Idle: no req_valid for 20 cycles -> m_valid = 0, rsp_valid = 0 and ptr unchanged throughout.

Source files
------------

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP multiplier among NREQ requesters.
// A tag pipeline routes each result back to the requester that issued it.
module fp_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          m_x,
    output logic [31:0]          m_y,
    output logic                 m_valid,
    input  logic [31:0]          m_out,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [4:0]           inflight
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] gnt_id_s;
    logic           gnt_s;
    logic           ret_s;
    logic [LAT-1:0] tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT];
    logic [4:0]     cnt_q;
    logic [4:0]     cnt_d;

    // Round-robin search from ptr; all grants are suppressed while reset is low.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_s     = 1'b0;
        gnt_id_s  = '0;
        req_ready = '0;
        m_valid   = 1'b0;
        m_x       = 32'h0000_0000;
        m_y       = 32'h0000_0000;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_s && reset && req_valid[idx]) begin
                gnt_s    = 1'b1;
                gnt_id_s = IDW'(idx);
            end else begin
                gnt_s    = gnt_s;
            end
        end
        if (gnt_s) begin
            req_ready[gnt_id_s] = 1'b1;
            m_valid             = 1'b1;
            m_x                 = req_x[int'(gnt_id_s)*32 +: 32];
            m_y                 = req_y[int'(gnt_id_s)*32 +: 32];
        end else begin
            m_valid             = 1'b0;
        end
    end

    // Pointer advance and in-flight count next state.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (gnt_s) begin
            ptr_d = (gnt_id_s == IDW'(NREQ - 1)) ? '0 : gnt_id_s + IDW'(1);
        end else begin
            ptr_d = ptr_q;
        end
        case ({gnt_s, ret_s})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Result routing: the oldest tag selects which requester sees m_out.
    always_comb begin
        ret_s     = reset && tag_vld_q[LAT-1];
        rsp_valid = '0;
        rsp_data  = 32'h0000_0000;
        if (ret_s) begin
            rsp_valid[tag_id_q[LAT-1]] = 1'b1;
            rsp_data                   = m_out;
        end else begin
            rsp_data                   = 32'h0000_0000;
        end
    end

    // State registers; a low reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q     <= '0;
            cnt_q     <= 5'd0;
            tag_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            tag_vld_q[0] <= gnt_s;
            tag_id_q[0]  <= gnt_id_s;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign inflight = cnt_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter (NREQ=4, LAT=4) with a stand-in multiplier pipeline.
module tb_fp_mult_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_x;
    logic [32*NREQ-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic [31:0]       m_x;
    logic [31:0]       m_y;
    logic              m_valid;
    logic [31:0]       m_out;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_data;
    logic [4:0]        inflight;

    int n_checks = 0;
    int n_pass   = 0;

    fp_mult_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .m_x       (m_x),
        .m_y       (m_y),
        .m_valid   (m_valid),
        .m_out     (m_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: exact product for 2.0*3.0, otherwise x+y so each result is traceable.
    function automatic logic [31:0] fake_mul(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h4000_0000 && y == 32'h4040_0000) begin
            return 32'h40C0_0000;
        end else begin
            return x + y;
        end
    endfunction

    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= m_valid ? fake_mul(m_x, m_y) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign m_out = mpipe[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) nxt();
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 4'hF;
        req_x     = '0;
        req_y     = '0;
        #1;

        // Reset: outputs forced low even with all requesters valid.
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_mvalid", 32'(m_valid), 32'h0);
        check_eq("rst_mx", m_x, 32'h0);
        check_eq("rst_rsp", 32'(rsp_valid), 32'h0);
        nxt();
        @(negedge clk);
        check_eq("rst_inflight", 32'(inflight), 32'h0);
        nxt();

        // Single request from requester 1: 2.0 * 3.0.
        reset          = 1'b1;
        req_valid      = 4'b0010;
        req_x[63:32]   = 32'h4000_0000;
        req_y[63:32]   = 32'h4040_0000;
        @(negedge clk);
        check_eq("single_ready", 32'(req_ready), 32'h2);
        check_eq("single_mvalid", 32'(m_valid), 32'h1);
        check_eq("single_mx", m_x, 32'h4000_0000);
        check_eq("single_my", m_y, 32'h4040_0000);
        nxt();
        req_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) check_eq("single_inflight1", 32'(inflight), 32'h1);
            if (c < 4)  check_eq("single_rsp_early", 32'(rsp_valid), 32'h0);
            if (c == 4) begin
                check_eq("single_rsp_valid", 32'(rsp_valid), 32'h2);
                check_eq("single_rsp_data", rsp_data, 32'h40C0_0000);
            end
            if (c == 5) check_eq("single_inflight0", 32'(inflight), 32'h0);
            nxt();
        end

        // Pointer now 2: grant 2 moves it to 3, then the wrap case.
        req_valid = 4'b0100;
        @(negedge clk);
        check_eq("wrap_setup", 32'(req_ready), 32'h4);
        nxt();
        req_valid = 4'b0101;
        @(negedge clk);
        check_eq("wrap_grant0", 32'(req_ready), 32'h1);
        nxt();
        @(negedge clk);
        check_eq("wrap_ptr1", 32'(req_ready), 32'h4);
        nxt();
        idle(LAT + 2);

        // Idle for 20 cycles: nothing issues or returns, pointer stays at 3.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("idle_quiet", {27'h0, m_valid, rsp_valid}, 32'h0);
            nxt();
        end
        req_valid = 4'b1001;
        @(negedge clk);
        check_eq("idle_ptr_kept", 32'(req_ready), 32'h8);
        nxt();
        idle(LAT + 1);

        // Mid-flight reset: three issues from requester 0, then one reset cycle.
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("mid_issue", 32'(req_ready), 32'h1);
            nxt();
        end
        req_valid = '0;
        reset     = 1'b0;
        @(negedge clk);
        check_eq("mid_inflight3", 32'(inflight), 32'h3);
        nxt();
        reset = 1'b1;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            check_eq("mid_no_rsp", 32'(rsp_valid), 32'h0);
            check_eq("mid_inflight0", 32'(inflight), 32'h0);
            nxt();
        end

        // Contention from reset: all four valid, one issue per cycle.
        reset = 1'b0;
        nxt();
        reset     = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_x[32*i +: 32] = 32'h3F80_0000 + 32'(i);
            req_y[32*i +: 32] = 32'h0000_0010 * 32'(i + 1);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_eq("cont_ready", 32'(req_ready), 32'h1 << (k % 4));
            check_eq("cont_mx", m_x, 32'h3F80_0000 + 32'(k % 4));
            check_eq("cont_inflight", 32'(inflight), 32'((k < LAT) ? k : LAT));
            if (k >= LAT) begin
                check_eq("cont_rsp_valid", 32'(rsp_valid), 32'h1 << ((k - LAT) % 4));
                check_eq("cont_rsp_data", rsp_data,
                         32'h3F80_0000 + 32'((k - LAT) % 4) + 32'h10 * 32'(((k - LAT) % 4) + 1));
            end
            nxt();
        end
        idle(LAT);
        @(negedge clk);
        check_eq("drain_inflight", 32'(inflight), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
